hoplite_nd_switch: RTL and testbench

- Registered, parametrised N-dimensional Hoplite torus switch; successor to the fixed 3-D combinational switch.
- Performs dimension-ordered routing internally from destination fields in the flit, so no external arbiter is needed.
- Arbitrates turns, ejection and PE injection; deflects losing flits on their own ring.
- Registers all outputs and counts deflections per dimension. Sits between the ring links and the PE in every torus node.

---
 rtl/hoplite_nd_switch.sv | 206 ++++++++++++++++++++
 tb/tb_hoplite_nd_switch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hoplite_nd_switch.sv
// rtl/hoplite_nd_switch.sv - registered N-dimensional Hoplite torus switch with deflection counters
module hoplite_nd_switch #(
  parameter int NUM_DIM   = 3,
  parameter int FLIT_SIZE = 128,
  parameter int COORD_W   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_DIM*COORD_W-1:0]   local_coord,
  input  logic [NUM_DIM-1:0]           in_valid,
  input  logic [NUM_DIM*FLIT_SIZE-1:0] in_flit,
  output logic [NUM_DIM-1:0]           out_valid,
  output logic [NUM_DIM*FLIT_SIZE-1:0] out_flit,
  input  logic                         pe_in_valid,
  input  logic [FLIT_SIZE-1:0]         pe_in_flit,
  output logic                         pe_in_ready,
  input  logic                         eject_ready,
  output logic                         eject_valid,
  output logic [FLIT_SIZE-1:0]         eject_flit,
  input  logic                         stat_clear,
  output logic [NUM_DIM*CNT_W-1:0]     deflect_count
);

  localparam int IDX_W = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1;

  logic [FLIT_SIZE-1:0] in_f [NUM_DIM];
  logic [COORD_W-1:0]   loc  [NUM_DIM];

  logic [NUM_DIM-1:0]   req_pass;
  logic [NUM_DIM-1:0]   req_turn;
  logic [NUM_DIM-1:0]   req_eject;
  logic [IDX_W-1:0]     turn_tgt [NUM_DIM];
  logic                 pe_req_eject;
  logic [IDX_W-1:0]     pe_tgt;

  logic [NUM_DIM-1:0]   out_valid_d, out_valid_q;
  logic [FLIT_SIZE-1:0] out_flit_d [NUM_DIM];
  logic [FLIT_SIZE-1:0] out_flit_q [NUM_DIM];
  logic                 eject_valid_d, eject_valid_q;
  logic [FLIT_SIZE-1:0] eject_flit_d, eject_flit_q;
  logic [CNT_W-1:0]     deflect_count_d [NUM_DIM];
  logic [CNT_W-1:0]     deflect_count_q [NUM_DIM];
  logic [NUM_DIM-1:0]   deflect;
  logic                 pe_grant;

  // Split the packed buses into per-dimension views
  always_comb begin
    for (int d = 0; d < NUM_DIM; d++) begin
      in_f[d] = in_flit[d*FLIT_SIZE +: FLIT_SIZE];
      loc[d]  = local_coord[d*COORD_W +: COORD_W];
    end
  end

  // Dimension-ordered route request for every ring input and the PE
  always_comb begin
    req_pass     = '0;
    req_turn     = '0;
    req_eject    = '0;
    pe_req_eject = 1'b1;
    pe_tgt       = '0;
    for (int d = 0; d < NUM_DIM; d++) begin
      turn_tgt[d] = '0;
    end
    for (int d = 0; d < NUM_DIM; d++) begin
      if (in_valid[d]) begin
        if (in_f[d][d*COORD_W +: COORD_W] != loc[d]) begin
          req_pass[d] = 1'b1;
        end else begin
          // Scan downward so the lowest mismatching higher dimension is kept
          for (int j = NUM_DIM - 1; j > d; j--) begin
            if (in_f[d][j*COORD_W +: COORD_W] != loc[j]) begin
              req_turn[d] = 1'b1;
              turn_tgt[d] = IDX_W'(j);
            end
          end
          req_eject[d] = !req_turn[d];
        end
      end
    end
    for (int j = NUM_DIM - 1; j >= 0; j--) begin
      if (pe_in_flit[j*COORD_W +: COORD_W] != loc[j]) begin
        pe_req_eject = 1'b0;
        pe_tgt       = IDX_W'(j);
      end
    end
  end

  // Arbitrate eject, then ring outputs from the top dimension down so every
  // turn target is resolved before its source input decides whether it stays
  always_comb begin
    logic                 ej_any;
    logic [IDX_W-1:0]     ej_sel;
    logic [NUM_DIM-1:0]   ej_won;
    logic [NUM_DIM-1:0]   turn_won;
    logic                 stays;
    logic                 tw_any;
    logic [IDX_W-1:0]     tw_sel;
    ej_any        = 1'b0;
    ej_sel        = '0;
    ej_won        = '0;
    turn_won      = '0;
    stays         = 1'b0;
    tw_any        = 1'b0;
    tw_sel        = '0;
    eject_valid_d = 1'b0;
    eject_flit_d  = '0;
    out_valid_d   = '0;
    deflect       = '0;
    pe_grant      = 1'b0;
    for (int d = 0; d < NUM_DIM; d++) begin
      out_flit_d[d] = '0;
    end

    for (int i = 0; i < NUM_DIM; i++) begin
      if (req_eject[i]) begin
        ej_any = 1'b1;
        ej_sel = IDX_W'(i);
      end
    end
    if (eject_ready && ej_any) begin
      ej_won[ej_sel] = 1'b1;
      eject_valid_d  = 1'b1;
      eject_flit_d   = in_f[ej_sel];
    end else if (eject_ready && pe_in_valid && pe_req_eject) begin
      eject_valid_d = 1'b1;
      eject_flit_d  = pe_in_flit;
      pe_grant      = 1'b1;
    end

    for (int d = NUM_DIM - 1; d >= 0; d--) begin
      stays = req_pass[d] || (req_turn[d] && !turn_won[d]) ||
              (req_eject[d] && !ej_won[d]);
      tw_any = 1'b0;
      tw_sel = '0;
      if (stays) begin
        out_valid_d[d] = 1'b1;
        out_flit_d[d]  = in_f[d];
        deflect[d]     = !req_pass[d];
      end else begin
        for (int i = 0; i < d; i++) begin
          if (req_turn[i] && (turn_tgt[i] == IDX_W'(d))) begin
            tw_any = 1'b1;
            tw_sel = IDX_W'(i);
          end
        end
        if (tw_any) begin
          turn_won[tw_sel] = 1'b1;
          out_valid_d[d]   = 1'b1;
          out_flit_d[d]    = in_f[tw_sel];
        end else if (pe_in_valid && !pe_req_eject && (pe_tgt == IDX_W'(d))) begin
          out_valid_d[d] = 1'b1;
          out_flit_d[d]  = pe_in_flit;
          pe_grant       = 1'b1;
        end
      end
    end
  end

  assign pe_in_ready = rst_n && pe_grant;

  // Saturating deflection counters; clear wins over a concurrent increment
  always_comb begin
    for (int d = 0; d < NUM_DIM; d++) begin
      deflect_count_d[d] = deflect_count_q[d];
      if (stat_clear) begin
        deflect_count_d[d] = '0;
      end else if (deflect[d] && (deflect_count_q[d] != {CNT_W{1'b1}})) begin
        deflect_count_d[d] = deflect_count_q[d] + CNT_W'(1);
      end
    end
  end

  // Output and statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= '0;
      eject_valid_q <= 1'b0;
      eject_flit_q  <= '0;
      for (int d = 0; d < NUM_DIM; d++) begin
        out_flit_q[d]      <= '0;
        deflect_count_q[d] <= '0;
      end
    end else begin
      out_valid_q   <= out_valid_d;
      eject_valid_q <= eject_valid_d;
      eject_flit_q  <= eject_flit_d;
      for (int d = 0; d < NUM_DIM; d++) begin
        out_flit_q[d]      <= out_flit_d[d];
        deflect_count_q[d] <= deflect_count_d[d];
      end
    end
  end

  // Repack registered state onto the output buses
  always_comb begin
    out_valid   = out_valid_q;
    eject_valid = eject_valid_q;
    eject_flit  = eject_flit_q;
    for (int d = 0; d < NUM_DIM; d++) begin
      out_flit[d*FLIT_SIZE +: FLIT_SIZE]  = out_flit_q[d];
      deflect_count[d*CNT_W +: CNT_W]     = deflect_count_q[d];
    end
  end

endmodule

// File: tb/tb_hoplite_nd_switch.sv
// tb/tb_hoplite_nd_switch.sv - scoreboard bench for hoplite_nd_switch at 3 dims, 2-bit coords, 32-bit flits
module tb_hoplite_nd_switch;

  localparam int ND = 3;
  localparam int FW = 32;
  localparam int CW = 2;
  localparam int KW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ND*CW-1:0] local_coord;
  logic [ND-1:0]   in_valid;
  logic [ND*FW-1:0] in_flit;
  logic [ND-1:0]   out_valid;
  logic [ND*FW-1:0] out_flit;
  logic            pe_in_valid;
  logic [FW-1:0]   pe_in_flit;
  logic            pe_in_ready;
  logic            eject_ready;
  logic            eject_valid;
  logic [FW-1:0]   eject_flit;
  logic            stat_clear;
  logic [ND*KW-1:0] deflect_count;

  hoplite_nd_switch #(.NUM_DIM(ND), .FLIT_SIZE(FW), .COORD_W(CW), .CNT_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .local_coord(local_coord),
    .in_valid(in_valid), .in_flit(in_flit),
    .out_valid(out_valid), .out_flit(out_flit),
    .pe_in_valid(pe_in_valid), .pe_in_flit(pe_in_flit), .pe_in_ready(pe_in_ready),
    .eject_ready(eject_ready), .eject_valid(eject_valid), .eject_flit(eject_flit),
    .stat_clear(stat_clear), .deflect_count(deflect_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] ov;
    logic [FW-1:0] f0, f1, f2;
    logic          ev;
    logic [FW-1:0] ef;
    logic [KW-1:0] c0, c1, c2;
  } exp_t;

  exp_t          sb[$];
  logic [KW-1:0] mc [ND];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int x, input int y, input int z, input logic [25:0] p);
    return {p, z[1:0], y[1:0], x[1:0]};
  endfunction

  task automatic set_in(input logic [ND-1:0] v, input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                        input logic [FW-1:0] f2);
    in_valid = v;
    in_flit  = {f2, f1, f0};
  endtask

  // Push the expected registered result, clock once, then pop and compare
  task automatic step(input logic [ND-1:0] ov, input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                      input logic [FW-1:0] f2, input logic ev, input logic [FW-1:0] ef,
                      input logic [ND-1:0] defl, input bit chk);
    exp_t e;
    for (int k = 0; k < ND; k++) begin
      if (!rst_n || stat_clear) mc[k] = '0;
      else if (defl[k] && mc[k] != 16'hFFFF) mc[k] = mc[k] + 16'd1;
    end
    e.ov = ov; e.f0 = f0; e.f1 = f1; e.f2 = f2; e.ev = ev; e.ef = ef;
    e.c0 = mc[0]; e.c1 = mc[1]; e.c2 = mc[2];
    if (chk) sb.push_back(e);
    @(posedge clk);
    #1;
    if (chk) begin
      e = sb.pop_front();
      check_eq("out_valid", 64'(out_valid), 64'(e.ov));
      check_eq("out_flit_x", 64'(out_flit[0*FW +: FW]), 64'(e.f0));
      check_eq("out_flit_y", 64'(out_flit[1*FW +: FW]), 64'(e.f1));
      check_eq("out_flit_z", 64'(out_flit[2*FW +: FW]), 64'(e.f2));
      check_eq("eject_valid", 64'(eject_valid), 64'(e.ev));
      check_eq("eject_flit", 64'(eject_flit), 64'(e.ef));
      check_eq("count_x", 64'(deflect_count[0*KW +: KW]), 64'(e.c0));
      check_eq("count_y", 64'(deflect_count[1*KW +: KW]), 64'(e.c1));
      check_eq("count_z", 64'(deflect_count[2*KW +: KW]), 64'(e.c2));
    end
  endtask

  logic [FW-1:0] fa, fb, fc, pf;

  initial begin
    for (int k = 0; k < ND; k++) mc[k] = '0;
    local_coord = {2'd1, 2'd1, 2'd1};
    rst_n       = 1'b0;
    stat_clear  = 1'b0;
    eject_ready = 1'b1;
    pe_in_valid = 1'b1;
    pe_in_flit  = mk(1, 1, 1, 26'h5);
    set_in(3'b111, mk(2, 0, 3, 26'h1), mk(1, 3, 0, 26'h2), mk(0, 0, 2, 26'h3));
    #1;
    check_eq("ready_in_reset", 64'(pe_in_ready), 64'd0);
    step('0, '0, '0, '0, 1'b0, '0, '0, 1);
    step('0, '0, '0, '0, 1'b0, '0, '0, 1);
    rst_n = 1'b1;

    // All three inputs pass through; PE wants Y and is refused
    fa = mk(2, 0, 3, 26'h11); fb = mk(1, 3, 0, 26'h22); fc = mk(0, 0, 2, 26'h33);
    set_in(3'b111, fa, fb, fc);
    pe_in_flit = mk(1, 2, 0, 26'h44);
    #1;
    check_eq("ready_all_pass", 64'(pe_in_ready), 64'd0);
    step(3'b111, fa, fb, fc, 1'b0, '0, 3'b000, 1);

    // Invalid inputs with junk data are ignored
    pe_in_valid = 1'b0;
    set_in(3'b000, mk(2, 2, 2, 26'h3ffffff), mk(0, 1, 1, 26'h7), mk(1, 1, 1, 26'h9));
    step('0, '0, '0, '0, 1'b0, '0, 3'b000, 1);

    // Two flits turn into Z: Y wins, X deflects on its own ring
    fa = mk(1, 1, 3, 26'h101); fb = mk(0, 1, 2, 26'h202);
    set_in(3'b011, fa, fb, mk(2, 2, 2, 26'h303));
    step(3'b101, fa, '0, fb, 1'b0, '0, 3'b001, 1);

    stat_clear = 1'b1;
    set_in(3'b000, '0, '0, '0);
    step('0, '0, '0, '0, 1'b0, '0, 3'b000, 1);
    stat_clear = 1'b0;

    // Eject contention: Z wins, X deflects; then eject blocked and both deflect
    fa = mk(1, 1, 1, 26'h55); fc = mk(1, 1, 1, 26'h66);
    set_in(3'b101, fa, '0, fc);
    step(3'b001, fa, '0, '0, 1'b1, fc, 3'b001, 1);
    eject_ready = 1'b0;
    step(3'b101, fa, '0, fc, 1'b0, '0, 3'b101, 1);
    eject_ready = 1'b1;

    // PE loopback loses the eject port to a ring flit
    fc = mk(1, 1, 1, 26'h77);
    set_in(3'b100, '0, '0, fc);
    pe_in_valid = 1'b1;
    pe_in_flit  = mk(1, 1, 1, 26'h88);
    #1;
    check_eq("ready_eject_busy", 64'(pe_in_ready), 64'd0);
    step('0, '0, '0, '0, 1'b1, fc, 3'b000, 1);

    // Injection into Y: blocked by passthrough, then granted
    fb = mk(3, 2, 3, 26'h99);
    pf = mk(1, 2, 0, 26'haa);
    set_in(3'b010, '0, fb, '0);
    pe_in_flit = pf;
    #1;
    check_eq("ready_y_busy", 64'(pe_in_ready), 64'd0);
    step(3'b010, '0, fb, '0, 1'b0, '0, 3'b000, 1);
    set_in(3'b000, '0, '0, '0);
    #1;
    check_eq("ready_y_free", 64'(pe_in_ready), 64'd1);
    step(3'b010, '0, pf, '0, 1'b0, '0, 3'b000, 1);

    // A turning ring flit beats the PE for output Z
    fa = mk(1, 1, 2, 26'hab);
    set_in(3'b001, fa, '0, '0);
    pe_in_flit = mk(1, 1, 0, 26'hac);
    #1;
    check_eq("ready_turn_wins", 64'(pe_in_ready), 64'd0);
    step(3'b100, '0, '0, fa, 1'b0, '0, 3'b000, 1);

    // Loopback with eject free, then with eject_ready low
    pf = mk(1, 1, 1, 26'hbb);
    set_in(3'b000, '0, '0, '0);
    pe_in_flit = pf;
    #1;
    check_eq("ready_loopback", 64'(pe_in_ready), 64'd1);
    step('0, '0, '0, '0, 1'b1, pf, 3'b000, 1);
    eject_ready = 1'b0;
    #1;
    check_eq("ready_loop_blocked", 64'(pe_in_ready), 64'd0);
    step('0, '0, '0, '0, 1'b0, '0, 3'b000, 1);
    pe_in_valid = 1'b0;

    // Counter saturation on X, then clear concurrent with a deflection
    stat_clear = 1'b1;
    step('0, '0, '0, '0, 1'b0, '0, 3'b000, 1);
    stat_clear = 1'b0;
    fa = mk(1, 1, 1, 26'hcc);
    set_in(3'b001, fa, '0, '0);
    for (int i = 0; i < 65537; i++) begin
      step(3'b001, fa, '0, '0, 1'b0, '0, 3'b001, (i == 65536));
    end
    stat_clear = 1'b1;
    step(3'b001, fa, '0, '0, 1'b0, '0, 3'b001, 1);
    stat_clear = 1'b0;

    // Reset in the middle of traffic drops everything
    eject_ready = 1'b1;
    fa = mk(2, 0, 3, 26'h123); fb = mk(1, 3, 0, 26'h234); fc = mk(0, 0, 2, 26'h345);
    set_in(3'b111, fa, fb, fc);
    step(3'b111, fa, fb, fc, 1'b0, '0, 3'b000, 1);
    set_in(3'b001, mk(2, 1, 1, 26'h456), '0, '0);
    pe_in_valid = 1'b1;
    pe_in_flit  = mk(1, 1, 1, 26'h567);
    rst_n = 1'b0;
    #1;
    check_eq("ready_mid_reset", 64'(pe_in_ready), 64'd0);
    step('0, '0, '0, '0, 1'b0, '0, 3'b000, 1);
    rst_n = 1'b1;
    pe_in_valid = 1'b0;
    set_in(3'b000, '0, '0, '0);
    step('0, '0, '0, '0, 1'b0, '0, 3'b000, 1);

    check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
